// File: rtl/mac_sequencer_if.sv
// rtl/mac_sequencer_if.sv - command, operand and result handshakes of the MAC sequencer
interface mac_sequencer_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int LEN_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_WIDTH-1:0] cmd_len;

    logic                 op_valid;
    logic                 op_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 op_add;

    logic                 res_valid;
    logic                 res_ready;
    logic [ACC_WIDTH-1:0] res_data;
    logic                 res_ovf;

    modport master (
        output cmd_valid, cmd_len, op_valid, op_a, op_b, op_add, res_ready,
        input  cmd_ready, op_ready, res_valid, res_data, res_ovf
    );

    modport slave (
        input  cmd_valid, cmd_len, op_valid, op_a, op_b, op_add, res_ready,
        output cmd_ready, op_ready, res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - command-driven up/down multiply-accumulate sequencer
module mac_sequencer #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int LEN_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    mac_sequencer_if.slave    bus,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] product;
    logic                 p_valid;
    logic                 p_add;
    logic                 ovf;
    logic                 cmd_ready_r;
    logic                 op_ready_r;
    logic                 res_valid_r;
    logic                 busy_r;

    logic                 cmd_xfer;
    logic                 op_xfer;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 acc_flag;

    assign cmd_xfer = bus.cmd_valid & cmd_ready_r;
    assign op_xfer  = bus.op_valid & op_ready_r;

    // Carry on add, borrow on subtract; both feed the sticky overflow flag.
    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, product};
        acc_next = p_add ? acc_sum[ACC_WIDTH-1:0] : acc - product;
        acc_flag = p_add ? acc_sum[ACC_WIDTH] : (product > acc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            acc         <= '0;
            product     <= '0;
            p_valid     <= 1'b0;
            p_add       <= 1'b0;
            ovf         <= 1'b0;
            cmd_ready_r <= 1'b1;
            op_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            p_valid <= op_xfer;
            if (op_xfer) begin
                // Truncating the operands first gives the same low bits as the full product.
                product <= ACC_WIDTH'(bus.op_a) * ACC_WIDTH'(bus.op_b);
                p_add   <= bus.op_add;
            end
            if (p_valid) begin
                acc <= acc_next;
                if (acc_flag) ovf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_xfer) begin
                        remaining   <= bus.cmd_len;
                        acc         <= '0;
                        ovf         <= 1'b0;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (bus.cmd_len != '0) begin
                            state      <= RUN;
                            op_ready_r <= 1'b1;
                        end else begin
                            state       <= DONE;
                            res_valid_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (op_xfer) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state      <= DRAIN;
                            op_ready_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state       <= DONE;
                    res_valid_r <= 1'b1;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Masking with reset keeps cmd_ready low for the whole reset assertion.
    assign bus.cmd_ready = cmd_ready_r & ~reset;
    assign bus.op_ready  = op_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = acc;
    assign bus.res_ovf   = ovf;
    assign busy          = busy_r;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - scoreboard bench for mac_sequencer with a reference dot-product model
module tb_mac_sequencer;
    localparam int WIDTH     = 8;
    localparam int ACC_WIDTH = 16;
    localparam int LEN_WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             add;
        int               gap;
    } op_t;

    typedef struct {
        logic [ACC_WIDTH-1:0] data;
        logic                 ovf;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    mac_sequencer_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

    mac_sequencer #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    op_t  pending[$];
    res_t exp_q[$];
    res_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   mode   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Dot product in plain integer arithmetic, wrapped modulo 2^ACC_WIDTH.
    function automatic res_t model();
        res_t  r;
        longint modv = longint'(1) << ACC_WIDTH;
        longint acc  = 0;
        longint p;
        bit    ov   = 0;
        foreach (pending[i]) begin
            p = (longint'(pending[i].a) * longint'(pending[i].b)) % modv;
            if (pending[i].add) begin
                acc = acc + p;
                if (acc >= modv) begin ov = 1; acc = acc - modv; end
            end else begin
                if (p > acc) begin ov = 1; acc = acc + modv; end
                acc = acc - p;
            end
        end
        r.data = ACC_WIDTH'(acc);
        r.ovf  = ov;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data=0x%0h, expected no result", bus.res_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_data", bus.res_data, mon_e.data);
                check("res_ovf", bus.res_ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       bus.res_ready = 1'b1;
                1:       bus.res_ready = 1'($urandom_range(0, 1));
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int len);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_WIDTH'(len);
        @(negedge clk);
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("cmd_ready_timeout", 0, 1);
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = LEN_WIDTH'($urandom);
    endtask

    task automatic send_op(input op_t o);
        int n = 0;
        repeat (o.gap) step();
        bus.op_valid = 1'b1;
        bus.op_a     = o.a;
        bus.op_b     = o.b;
        bus.op_add   = o.add;
        @(negedge clk);
        while (!bus.op_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("op_ready_timeout", 0, 1);
        step();
        bus.op_valid = 1'b0;
        bus.op_a     = WIDTH'($urandom);
        bus.op_b     = WIDTH'($urandom);
    endtask

    task automatic add_op(input int a, input int b, input bit add, input int gap);
        op_t o;
        o.a = WIDTH'(a);
        o.b = WIDTH'(b);
        o.add = add;
        o.gap = gap;
        pending.push_back(o);
    endtask

    task automatic issue_job();
        exp_q.push_back(model());
        send_cmd(pending.size());
        foreach (pending[i]) send_op(pending[i]);
        pending.delete();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("result_timeout", exp_q.size(), 0);
        step();
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_add    = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_op_ready", bus.op_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_ovf", bus.res_ovf, 0);
        check("rst_busy", busy, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", bus.cmd_ready, 1);
        step();

        // Basic three-element job with latency checks
        add_op(2, 3, 1, 0);
        add_op(4, 5, 1, 0);
        add_op(10, 1, 0, 0);
        issue_job();
        @(negedge clk);
        check("t1_op_ready_fall", bus.op_ready, 0);
        check("t1_res_valid_drain", bus.res_valid, 0);
        @(negedge clk);
        check("t1_res_valid_rise", bus.res_valid, 1);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_res_valid_one_cycle", bus.res_valid, 0);
        check("t1_cmd_ready_back", bus.cmd_ready, 1);
        step();

        // Zero-length command
        pending.delete();
        issue_job();
        @(negedge clk);
        check("t2_res_valid", bus.res_valid, 1);
        check("t2_op_ready", bus.op_ready, 0);
        @(negedge clk);
        check("t2_idle_busy", busy, 0);
        check("t2_idle_cmd_ready", bus.cmd_ready, 1);
        step();

        // Carry wrap, then borrow, then clean restart
        add_op(255, 255, 1, 0);
        add_op(255, 255, 1, 0);
        issue_job();
        wait_drain();
        add_op(1, 1, 0, 0);
        issue_job();
        wait_drain();
        add_op(3, 3, 1, 0);
        issue_job();
        wait_drain();

        // Operand gaps and result backpressure
        mode = 2;
        add_op(1, 1, 1, 0);
        add_op(1, 1, 1, 2);
        add_op(1, 1, 1, 0);
        add_op(1, 1, 1, 1);
        issue_job();
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", bus.res_valid, 1);
            check("t5_hold_data", bus.res_data, 4);
            check("t5_hold_ovf", bus.res_ovf, 0);
            check("t5_hold_cmd_ready", bus.cmd_ready, 0);
            check("t5_hold_busy", busy, 1);
            @(negedge clk);
        end
        mode = 0;
        wait_drain();

        // Reset in the middle of a job
        send_cmd(4);
        add_op(9, 9, 1, 0);
        send_op(pending[0]);
        pending.delete();
        reset = 1'b1;
        @(negedge clk);
        check("t6_cmd_ready_in_reset", bus.cmd_ready, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_res_valid", bus.res_valid, 0);
        check("t6_cmd_ready", bus.cmd_ready, 1);
        check("t6_op_ready", bus.op_ready, 0);
        step();
        add_op(7, 7, 1, 0);
        issue_job();
        wait_drain();

        // Randomized jobs with random result backpressure
        mode = 1;
        for (int j = 0; j < 40; j++) begin
            int len = $urandom_range(0, 6);
            for (int k = 0; k < len; k++) begin
                add_op(($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
                       ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0);
            end
            issue_job();
        end
        wait_drain();
        mode = 0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
